// File: rtl/tick_pwm_gen.sv
// tick_pwm_gen
//   Tick-domain PWM generator. It counts enable ticks from an upstream
//   clock-enable divider. Period and duty are expressed in ticks. New
//   configuration is double-buffered and takes effect only at a start tick
//   or a period boundary, so a period already in progress is never changed.
//
// Ports
//   clk          system clock (single clock domain)
//   rst          synchronous, active-high reset
//   tick_in      one-clk enable pulse; the counter and FSM advance only on it
//   en           run request, sampled on the start tick and at boundaries
//   cfg_load     strobe that captures period_in/duty_in
//   period_in    new period value (period length = period_in+1 ticks)
//   duty_in      new duty value (high ticks per period)
//   pwm_out      registered PWM waveform
//   period_done  one-clk pulse at each period boundary
//   cfg_pending  a captured config is waiting for a boundary
//   periods_cnt  completed-period counter, wraps
//   running      registered copy of (state == RUN)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | stopped, pwm_out low, waits for a tick with en=1
// RUN   | counting ticks 0..period_act, boundary at cnt==period_act

module tick_pwm_gen #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PERIOD_RST = 3,
  parameter int unsigned DUTY_RST   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] duty_in,
  output logic             pwm_out,
  output logic             period_done,
  output logic             cfg_pending,
  output logic [WIDTH-1:0] periods_cnt,
  output logic             running
);

  localparam logic [WIDTH-1:0] PERIOD_RST_V = WIDTH'(PERIOD_RST);
  localparam logic [WIDTH-1:0] DUTY_RST_V   = WIDTH'(DUTY_RST);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] period_act, period_act_nxt;
  logic [WIDTH-1:0] duty_act, duty_act_nxt;
  logic [WIDTH-1:0] period_pend, period_pend_nxt;
  logic [WIDTH-1:0] duty_pend, duty_pend_nxt;
  logic             cfg_pending_nxt;
  logic [WIDTH-1:0] periods_cnt_nxt;
  logic             period_done_nxt;
  logic             pwm_nxt;
  logic             apply_cfg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      period_act  <= PERIOD_RST_V;
      duty_act    <= DUTY_RST_V;
      period_pend <= '0;
      duty_pend   <= '0;
      cfg_pending <= 1'b0;
      periods_cnt <= '0;
      period_done <= 1'b0;
      pwm_out     <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      period_act  <= period_act_nxt;
      duty_act    <= duty_act_nxt;
      period_pend <= period_pend_nxt;
      duty_pend   <= duty_pend_nxt;
      cfg_pending <= cfg_pending_nxt;
      periods_cnt <= periods_cnt_nxt;
      period_done <= period_done_nxt;
      pwm_out     <= pwm_nxt;
      running     <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    period_act_nxt  = period_act;
    duty_act_nxt    = duty_act;
    period_pend_nxt = period_pend;
    duty_pend_nxt   = duty_pend;
    cfg_pending_nxt = cfg_pending;
    periods_cnt_nxt = periods_cnt;
    period_done_nxt = 1'b0;
    apply_cfg       = 1'b0;

    case (state)
      IDLE: begin
        if (tick_in && en) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          apply_cfg = 1'b1;
        end
      end
      RUN: begin
        if (tick_in) begin
          if (cnt == period_act) begin
            cnt_nxt         = '0;
            period_done_nxt = 1'b1;
            periods_cnt_nxt = periods_cnt + WIDTH'(1);
            apply_cfg       = 1'b1;
            if (!en) state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + WIDTH'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A load that lands on the apply edge itself bypasses the pending regs,
    // so the newest value wins and nothing is left waiting.
    if (apply_cfg) begin
      if (cfg_load) begin
        period_act_nxt = period_in;
        duty_act_nxt   = duty_in;
      end else if (cfg_pending) begin
        period_act_nxt = period_pend;
        duty_act_nxt   = duty_pend;
      end
      cfg_pending_nxt = 1'b0;
    end else if (cfg_load) begin
      period_pend_nxt = period_in;
      duty_pend_nxt   = duty_in;
      cfg_pending_nxt = 1'b1;
    end

    // Computed from the next-state values so pwm_out lines up with cnt.
    pwm_nxt = (state_nxt == RUN) && (cnt_nxt < duty_act_nxt);
  end

endmodule

// File: tb/tb_tick_pwm_gen.sv
// Directed bench for tick_pwm_gen: ticks every 4 clks (or back-to-back for
// the wrap run), expected values hand-computed per tick.

module tb_tick_pwm_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       en;
  logic       cfg_load;
  logic [7:0] period_in;
  logic [7:0] duty_in;
  logic       pwm_out;
  logic       period_done;
  logic       cfg_pending;
  logic [7:0] periods_cnt;
  logic       running;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tick_pwm_gen #(.WIDTH(8), .PERIOD_RST(3), .DUTY_RST(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_in     (tick_in),
    .en          (en),
    .cfg_load    (cfg_load),
    .period_in   (period_in),
    .duty_in     (duty_in),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .cfg_pending (cfg_pending),
    .periods_cnt (periods_cnt),
    .running     (running)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clk cycle; inputs are driven 1 time unit after the rising edge.
  task automatic cyc(input logic t, input logic ld);
    tick_in  = t;
    cfg_load = ld;
    @(posedge clk);
    #1;
    tick_in  = 1'b0;
    cfg_load = 1'b0;
  endtask

  // One tick followed by three idle clks; pwm_out must hold across all four.
  task automatic tk(input string tag, input logic ld, input logic ep, input logic ed);
    cyc(1'b1, ld);
    chk({tag, "_pwm"}, pwm_out, ep);
    chk({tag, "_done"}, period_done, ed);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0);
      chk({tag, "_pwm_hold"}, pwm_out, ep);
      chk({tag, "_done_low"}, period_done, 1'b0);
    end
  endtask

  task automatic load_mid(input logic [7:0] p, input logic [7:0] d);
    period_in = p;
    duty_in   = d;
    cyc(1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; tick_in = 1'b0; en = 1'b0; cfg_load = 1'b0;
    period_in = '0; duty_in = '0;
    #2;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_done", period_done, 0);
    chk("rst_pend", cfg_pending, 0);
    chk("rst_periods", periods_cnt, 0);
    chk("rst_running", running, 0);
    rst = 1'b0;

    // 1: defaults 3/1
    en = 1'b1;
    tk("p1_start", 0, 1, 0);
    chk("p1_running", running, 1);
    for (int i = 0; i < 3; i++) tk("p1_low", 0, 0, 0);
    tk("p1_bnd1", 0, 1, 1);
    chk("p1_periods1", periods_cnt, 1);
    for (int i = 0; i < 3; i++) tk("p1_low2", 0, 0, 0);
    tk("p1_bnd2", 0, 1, 1);
    chk("p1_periods2", periods_cnt, 2);

    // 2: mid-period load 7/4
    load_mid(8'd7, 8'd4);
    chk("p2_pend", cfg_pending, 1);
    for (int i = 0; i < 3; i++) tk("p2_old_low", 0, 0, 0);
    chk("p2_pend_hold", cfg_pending, 1);
    tk("p2_bnd", 0, 1, 1);
    chk("p2_pend_clr", cfg_pending, 0);
    chk("p2_periods", periods_cnt, 3);
    for (int i = 0; i < 3; i++) tk("p2_high", 0, 1, 0);
    for (int i = 0; i < 4; i++) tk("p2_low", 0, 0, 0);
    tk("p2_bnd2", 0, 1, 1);
    chk("p2_periods2", periods_cnt, 4);

    // 3: last load wins, then bypass on a boundary tick
    load_mid(8'd5, 8'd2);
    tk("p3_c1", 0, 1, 0);
    load_mid(8'd2, 8'd2);
    chk("p3_pend", cfg_pending, 1);
    for (int i = 0; i < 2; i++) tk("p3_old_high", 0, 1, 0);
    for (int i = 0; i < 4; i++) tk("p3_old_low", 0, 0, 0);
    tk("p3_bnd", 0, 1, 1);
    chk("p3_pend_clr", cfg_pending, 0);
    tk("p3_c1b", 0, 1, 0);
    tk("p3_c2b", 0, 0, 0);
    period_in = 8'd9;
    duty_in   = 8'd9;
    tk("p3_bypass_bnd", 1, 1, 1);
    chk("p3_bypass_pend", cfg_pending, 0);
    chk("p3_periods", periods_cnt, 6);
    for (int i = 0; i < 8; i++) tk("p3_9_high", 0, 1, 0);
    tk("p3_9_low", 0, 0, 0);
    tk("p3_9_bnd", 0, 1, 1);
    chk("p3_periods2", periods_cnt, 7);

    // 4: duty=0, duty>period, period=0
    load_mid(8'd3, 8'd0);
    for (int i = 0; i < 8; i++) tk("p4_9_high", 0, 1, 0);
    tk("p4_9_low", 0, 0, 0);
    tk("p4_d0_bnd", 0, 0, 1);
    for (int i = 0; i < 3; i++) tk("p4_d0", 0, 0, 0);
    tk("p4_d0_bnd2", 0, 0, 1);
    chk("p4_periods_d0", periods_cnt, 9);
    load_mid(8'd3, 8'd10);
    for (int i = 0; i < 3; i++) tk("p4_d0b", 0, 0, 0);
    tk("p4_d10_bnd", 0, 1, 1);
    for (int i = 0; i < 3; i++) tk("p4_d10", 0, 1, 0);
    tk("p4_d10_bnd2", 0, 1, 1);
    load_mid(8'd0, 8'd1);
    for (int i = 0; i < 3; i++) tk("p4_d10b", 0, 1, 0);
    tk("p4_p0_a", 0, 1, 1);
    tk("p4_p0_b", 0, 1, 1);
    tk("p4_p0_c", 0, 1, 1);
    chk("p4_periods_p0", periods_cnt, 14);

    // 5: en drop/restore, stop at boundary, idle load, restart
    load_mid(8'd3, 8'd1);
    tk("p5_bnd", 0, 1, 1);
    tk("p5_c1", 0, 0, 0);
    en = 1'b0;
    tk("p5_c2_enlow", 0, 0, 0);
    chk("p5_run_mid", running, 1);
    en = 1'b1;
    tk("p5_c3", 0, 0, 0);
    tk("p5_bnd2", 0, 1, 1);
    chk("p5_periods", periods_cnt, 16);
    en = 1'b0;
    for (int i = 0; i < 3; i++) tk("p5_stop_cnt", 0, 0, 0);
    chk("p5_run_before_stop", running, 1);
    tk("p5_stop_bnd", 0, 0, 1);
    chk("p5_stopped", running, 0);
    chk("p5_periods2", periods_cnt, 17);
    load_mid(8'd1, 8'd2);
    chk("p5_idle_pend", cfg_pending, 1);
    tk("p5_idle_tick", 0, 0, 0);
    chk("p5_idle_run", running, 0);
    en = 1'b1;
    tk("p5_restart", 0, 1, 0);
    chk("p5_restart_run", running, 1);
    chk("p5_restart_pend", cfg_pending, 0);
    tk("p5_r_c1", 0, 1, 0);
    tk("p5_r_bnd", 0, 1, 1);
    chk("p5_periods3", periods_cnt, 18);

    // 6: reset mid-period with pwm high, then wrap
    load_mid(8'd5, 8'd5);
    chk("p6_pre_pwm", pwm_out, 1);
    chk("p6_pre_pend", cfg_pending, 1);
    rst = 1'b1;
    cyc(1'b1, 1'b0);
    rst = 1'b0;
    chk("p6_rst_pwm", pwm_out, 0);
    chk("p6_rst_run", running, 0);
    chk("p6_rst_pend", cfg_pending, 0);
    chk("p6_rst_periods", periods_cnt, 0);
    chk("p6_rst_done", period_done, 0);
    tk("p6_start", 0, 1, 0);
    for (int i = 0; i < 3; i++) tk("p6_low", 0, 0, 0);
    tk("p6_bnd", 0, 1, 1);
    chk("p6_periods1", periods_cnt, 1);
    load_mid(8'd0, 8'd1);
    for (int i = 0; i < 3; i++) tk("p6_low2", 0, 0, 0);
    tk("p6_p0_bnd", 0, 1, 1);
    chk("p6_periods2", periods_cnt, 2);
    for (int i = 0; i < 253; i++) cyc(1'b1, 1'b0);
    chk("p6_periods255", periods_cnt, 255);
    cyc(1'b1, 1'b0);
    chk("p6_wrap", periods_cnt, 0);
    chk("p6_wrap_done", period_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
